// File: rtl/jtag_dbg_pkg.sv
// Shared constants for the USER2 JTAG-to-memory debug bridge: DR layout, command codes, FSM states.
package jtag_dbg_pkg;

    localparam int DR_W        = 66;
    localparam int CMD_W       = 2;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 30;
    localparam int TMO_W       = 8;
    localparam int DR_CMD_LSB  = 0;
    localparam int DR_DATA_LSB = 2;
    localparam int DR_ADDR_LSB = 34;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_CLR   = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Status word loaded into the DR on CAPTURE; err lands in bit 0 so it is shifted out first.
    function automatic logic [DR_W-1:0] capture_word(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rdata,
        input logic              ovr,
        input logic              err
    );
        return {2'b00, addr, rdata, ovr, err};
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Synchroniser for one asynchronous JTAG fabric signal, plus single-cycle rise/fall strobes in clk.
module jtag_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/jtag_mem_bridge.sv
// Debug master on the BSCAN USER2 chain: oversamples the TAP signals in clk, shifts a 66-bit DR and
// turns each UPDATE into one 32-bit read or write on the memory bus with req/ack and a timeout.
module jtag_mem_bridge
    import jtag_dbg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jtag_tck,
    input  logic        jtag_tdi,
    input  logic        jtag_sel,
    input  logic        jtag_capture,
    input  logic        jtag_shift,
    input  logic        jtag_update,
    input  logic        jtag_reset,
    output logic        jtag_tdo,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy
);

    logic tck_rise, tck_fall, upd_rise, upd_fall_unused;
    logic tdi_s, sel_s, cap_s, shift_s, jrst_s;

    logic [SYNC_STAGES-1:0][4:0] lvl_sync_q, lvl_sync_d;

    logic [DR_W-1:0]   sr_q, sr_d;
    logic              tdo_q, tdo_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    state_e            state_q, state_d;

    cmd_e upd_cmd;
    logic upd_act, start, ack_hit, tmo_hit;

    jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tck_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (jtag_tck),
        .rise     (tck_rise),
        .fall     (tck_fall)
    );

    jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_upd_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (jtag_update),
        .rise     (upd_rise),
        .fall     (upd_fall_unused)
    );

    always_comb begin
        lvl_sync_d = {lvl_sync_q[SYNC_STAGES-2:0],
                      {jtag_tdi, jtag_sel, jtag_capture, jtag_shift, jtag_reset}};
    end

    assign {tdi_s, sel_s, cap_s, shift_s, jrst_s} = lvl_sync_q[SYNC_STAGES-1];

    assign upd_cmd = cmd_e'(sr_q[DR_CMD_LSB +: CMD_W]);
    assign upd_act = upd_rise & sel_s;
    assign start   = upd_act & ~busy & ((upd_cmd == CMD_READ) || (upd_cmd == CMD_WRITE));
    assign ack_hit = busy & bus_ack;
    // An ack arriving in the final timeout cycle still completes the transfer.
    assign tmo_hit = busy & ~bus_ack & (tmo_q == TMO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (ack_hit || tmo_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // TAP data register; TDO changes on the falling TCK so the host samples a settled bit on the rise.
    always_comb begin
        sr_d  = sr_q;
        tdo_d = tdo_q;
        if (jrst_s) begin
            sr_d = '0;
        end else if (tck_rise && sel_s && cap_s) begin
            sr_d = capture_word(last_addr_q, rdata_q, ovr_q, err_q);
        end else if (tck_rise && sel_s && shift_s) begin
            sr_d = {tdi_s, sr_q[DR_W-1:1]};
        end
        if (tck_fall && sel_s) begin
            tdo_d = sr_q[0];
        end
    end

    always_comb begin
        err_d = err_q;
        ovr_d = ovr_q;
        if (tmo_hit) begin
            err_d = 1'b1;
        end
        if (upd_act) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else if (upd_cmd == CMD_CLR) begin
                err_d = 1'b0;
                ovr_d = 1'b0;
            end
        end
        if (jrst_s) begin
            err_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_addr_d = last_addr_q;
        rdata_d     = rdata_q;
        tmo_d       = (state_q == ST_REQ) ? tmo_q + TMO_W'(1) : '0;
        if (start) begin
            we_d        = (upd_cmd == CMD_WRITE);
            addr_d      = sr_q[DR_ADDR_LSB +: ADDR_W];
            wdata_d     = sr_q[DR_DATA_LSB +: DATA_W];
            last_addr_d = sr_q[DR_ADDR_LSB +: ADDR_W];
        end
        if (ack_hit && !we_q) begin
            rdata_d = bus_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_sync_q  <= '0;
            sr_q        <= '0;
            tdo_q       <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            rdata_q     <= '0;
            last_addr_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            tmo_q       <= '0;
        end else begin
            lvl_sync_q  <= lvl_sync_d;
            sr_q        <= sr_d;
            tdo_q       <= tdo_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            rdata_q     <= rdata_d;
            last_addr_q <= last_addr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            tmo_q       <= tmo_d;
        end
    end

    assign jtag_tdo  = tdo_q;
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q, 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_be    = 4'hF;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Bench for jtag_mem_bridge: plays a JTAG host and a memory slave, checks against a status model.
module tb_jtag_mem_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        jtag_tck, jtag_tdi, jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_reset;
    logic        jtag_tdo;
    logic        bus_req, bus_we, bus_ack, busy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;
    int req_high  = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    logic        m_err, m_ovr;
    logic [31:0] m_rdata;
    logic [29:0] m_addr;

    typedef struct {
        logic [1:0]  cmd;
        logic [29:0] waddr;
        logic [31:0] data;
        int          delay;
        logic [31:0] ack_rdata;
        logic        exp_req;
        logic [31:0] exp_bus_addr;
        logic [31:0] exp_rdata;
        logic [29:0] exp_last;
    } vec_t;

    vec_t        vecs [6];
    logic [65:0] dout;
    logic [65:0] held;
    logic [1:0]  rcmd;
    logic [29:0] ra;
    logic [31:0] rdat, rbus;
    int          dly;
    logic        noack;
    int          n;

    always #5 clk = ~clk;

    jtag_mem_bridge #(.SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .jtag_tck     (jtag_tck),
        .jtag_tdi     (jtag_tdi),
        .jtag_sel     (jtag_sel),
        .jtag_capture (jtag_capture),
        .jtag_shift   (jtag_shift),
        .jtag_update  (jtag_update),
        .jtag_reset   (jtag_reset),
        .jtag_tdo     (jtag_tdo),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .busy         (busy)
    );

    // Counts request cycles and request starts so transaction length and overruns can be checked.
    always @(negedge clk) begin
        if (bus_req) req_high++;
        if (bus_req && !req_prev) req_rises++;
        req_prev = bus_req;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int cnt);
        repeat (cnt) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clearCounters();
        req_high  = 0;
        req_rises = 0;
    endtask

    function automatic logic [65:0] drWord(input logic [1:0] cmd, input logic [29:0] a, input logic [31:0] d);
        return {2'b00, a, d, cmd};
    endfunction

    function automatic logic [65:0] modelStatus();
        return {2'b00, m_addr, m_rdata, m_ovr, m_err};
    endfunction

    // One full DR scan: capture, 66 shifts (LSB first) sampling TDO before each rise, then update.
    task automatic applyStimulus(input logic sel_v, input logic [65:0] din, output logic [65:0] dout_o);
        jtag_sel     = sel_v;
        jtag_capture = 1'b1;
        jtag_shift   = 1'b0;
        step(5);
        jtag_tck = 1'b1;
        step(5);
        jtag_tck     = 1'b0;
        jtag_capture = 1'b0;
        jtag_shift   = 1'b1;
        step(5);
        for (int i = 0; i < 66; i++) begin
            jtag_tdi  = din[i];
            dout_o[i] = jtag_tdo;
            step(3);
            jtag_tck = 1'b1;
            step(5);
            jtag_tck = 1'b0;
            step(5);
        end
        jtag_shift  = 1'b0;
        jtag_update = 1'b1;
        step(6);
        jtag_update = 1'b0;
        step(2);
    endtask

    task automatic pulseUpdate();
        jtag_sel = 1'b1;
        step(2);
        jtag_update = 1'b1;
        step(4);
        jtag_update = 1'b0;
        step(2);
    endtask

    task automatic statusScan(input string name);
        logic [65:0] d;
        applyStimulus(1'b1, drWord(2'b00, 30'h0, 32'h0), d);
        checkOutput(name, d, modelStatus());
    endtask

    // Acts as the memory slave: acks once the request has been up for delay+1 cycles.
    task automatic serviceBus(input logic exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input int delay, input logic [31:0] rdata);
        int k = 0;
        while ((req_rises == 0 || req_high < delay + 1) && k < 100) begin
            step(1);
            k++;
        end
        checkOutput("req_wait", {64'b0, k < 100, bus_req}, 66'b11);
        checkOutput("bus_we", bus_we, exp_we);
        checkOutput("bus_addr", bus_addr, exp_addr);
        if (exp_we) checkOutput("bus_wdata", bus_wdata, exp_wdata);
        checkOutput("bus_be", bus_be, 4'hF);
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        step(1);
        bus_ack   = 1'b0;
        bus_rdata = ~rdata;
        checkOutput("req_drop", {bus_req, busy}, 2'b00);
    endtask

    task automatic waitReqDone(input string name);
        int k = 0;
        while ((req_rises == 0 || bus_req) && k < 200) begin
            step(1);
            k++;
        end
        checkOutput(name, {64'b0, req_rises != 0, bus_req}, 66'b10);
    endtask

    initial begin
        vecs[0] = '{2'b10, 30'h40,       32'hDEADBEEF, 6,  32'h0,        1'b1, 32'h100,      32'h0,        30'h40};
        vecs[1] = '{2'b01, 30'h40,       32'h0,        8,  32'hDEADBEEF, 1'b1, 32'h100,      32'hDEADBEEF, 30'h40};
        vecs[2] = '{2'b00, 30'h1234,     32'h55,       0,  32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 30'h40};
        vecs[3] = '{2'b10, 30'h3FFFFFFF, 32'h0,        16, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFC, 32'hDEADBEEF, 30'h3FFFFFFF};
        vecs[4] = '{2'b01, 30'h3FFFFFFF, 32'h1,        16, 32'hA5A55A5A, 1'b1, 32'hFFFFFFFC, 32'hA5A55A5A, 30'h3FFFFFFF};
        vecs[5] = '{2'b01, 30'h0,        32'h0,        6,  32'h00000001, 1'b1, 32'h0,        32'h00000001, 30'h0};

        rst = 1'b1;
        jtag_tck = 0; jtag_tdi = 0; jtag_sel = 0; jtag_capture = 0;
        jtag_shift = 0; jtag_update = 0; jtag_reset = 0;
        bus_ack = 0; bus_rdata = 32'h0;
        m_err = 0; m_ovr = 0; m_rdata = 32'h0; m_addr = 30'h0;
        step(3);
        checkOutput("rst_bus_req", bus_req, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_bus_we", bus_we, 1'b0);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
        checkOutput("rst_bus_be", bus_be, 4'hF);
        checkOutput("rst_tdo", jtag_tdo, 1'b0);
        rst = 1'b0;
        step(5);
        statusScan("init_status");

        $display("[TB] directed vector table");
        for (int v = 0; v < 6; v++) begin
            clearCounters();
            applyStimulus(1'b1, drWord(vecs[v].cmd, vecs[v].waddr, vecs[v].data), dout);
            if (vecs[v].exp_req) begin
                serviceBus(vecs[v].cmd == 2'b10, vecs[v].exp_bus_addr, vecs[v].data, vecs[v].delay, vecs[v].ack_rdata);
            end else begin
                step(10);
                checkOutput("vec_no_req", req_rises, 0);
            end
            m_rdata = vecs[v].exp_rdata;
            m_addr  = vecs[v].exp_last;
            applyStimulus(1'b1, drWord(2'b00, 30'h0, 32'h0), dout);
            checkOutput("vec_status", dout, {2'b00, vecs[v].exp_last, vecs[v].exp_rdata, 2'b00});
        end

        $display("[TB] timeout then clear");
        clearCounters();
        applyStimulus(1'b1, drWord(2'b01, 30'h5, 32'h0), dout);
        waitReqDone("tmo_done");
        checkOutput("tmo_req_cycles", req_high, TMO + 1);
        checkOutput("tmo_req_rises", req_rises, 1);
        m_err  = 1'b1;
        m_addr = 30'h5;
        statusScan("tmo_status");
        applyStimulus(1'b1, drWord(2'b11, 30'h0, 32'h0), dout);
        m_err = 1'b0;
        m_ovr = 1'b0;
        statusScan("clr_status");

        $display("[TB] overrun then TAP reset");
        clearCounters();
        applyStimulus(1'b1, drWord(2'b10, 30'h2A, 32'h0BADF00D), dout);
        pulseUpdate();
        serviceBus(1'b1, 32'hA8, 32'h0BADF00D, 14, 32'h0);
        step(10);
        checkOutput("ovr_single_req", req_rises, 1);
        m_addr = 30'h2A;
        m_ovr  = 1'b1;
        statusScan("ovr_status");
        jtag_reset = 1'b1;
        step(6);
        jtag_reset = 1'b0;
        step(4);
        m_err = 1'b0;
        m_ovr = 1'b0;
        statusScan("jreset_status");

        $display("[TB] sel low ignores the TAP");
        held = drWord(2'b11, 30'h0, 32'h0);
        applyStimulus(1'b1, held, dout);
        held = held[0] ? '1 : '0;
        clearCounters();
        applyStimulus(1'b0, drWord(2'b10, 30'h77, 32'h12345678), dout);
        step(20);
        checkOutput("sel0_no_req", req_rises, 0);
        checkOutput("sel0_tdo_hold", dout, held);
        statusScan("sel0_status");

        $display("[TB] reset during request");
        clearCounters();
        applyStimulus(1'b1, drWord(2'b01, 30'h77, 32'h0), dout);
        n = 0;
        while (!bus_req && n < 50) begin
            step(1);
            n++;
        end
        checkOutput("rst_mid_req_seen", bus_req, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_drop", {bus_req, busy}, 2'b00);
        step(1);
        rst = 1'b0;
        m_err = 0; m_ovr = 0; m_rdata = 32'h0; m_addr = 30'h0;
        step(3);
        bus_rdata = 32'h12345678;
        bus_ack   = 1'b1;
        step(1);
        bus_ack = 1'b0;
        step(3);
        checkOutput("idle_ack_no_req", bus_req, 1'b0);
        statusScan("rst_mid_status");
        applyStimulus(1'b1, drWord(2'b01, 30'h123, 32'h0), dout);
        serviceBus(1'b0, 32'h48C, 32'h0, 7, 32'hCAFEF00D);
        m_addr  = 30'h123;
        m_rdata = 32'hCAFEF00D;
        statusScan("post_rst_read");

        $display("[TB] randomized commands");
        for (int k = 0; k < 10; k++) begin
            rcmd  = 2'($urandom_range(0, 3));
            ra    = 30'($urandom);
            rdat  = $urandom;
            rbus  = $urandom;
            dly   = $urandom_range(6, 15);
            noack = ($urandom_range(0, 4) == 0);
            clearCounters();
            applyStimulus(1'b1, drWord(rcmd, ra, rdat), dout);
            checkOutput("rand_capture", dout, modelStatus());
            if (rcmd == 2'b01 || rcmd == 2'b10) begin
                if (noack) begin
                    waitReqDone("rand_tmo_done");
                    checkOutput("rand_tmo_cycles", req_high, TMO + 1);
                    m_err = 1'b1;
                end else begin
                    serviceBus(rcmd == 2'b10, {ra, 2'b00}, rdat, dly, rbus);
                    if (rcmd == 2'b01) m_rdata = rbus;
                end
                m_addr = ra;
            end else begin
                if (rcmd == 2'b11) begin
                    m_err = 1'b0;
                    m_ovr = 1'b0;
                end
                step(10);
                checkOutput("rand_no_req", req_rises, 0);
            end
        end
        statusScan("final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
